// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants and receive-FSM state encoding,
// common to udp_rx and udp_tx.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
    localparam logic [7:0]  UDP_PROTO     = 8'd17;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;

    // One-hot receive states
    typedef enum logic [6:0] {
        st_idle     = 7'b000_0001,
        st_preamble = 7'b000_0010,
        st_eth_head = 7'b000_0100,
        st_ip_head  = 7'b000_1000,
        st_udp_head = 7'b001_0000,
        st_rx_data  = 7'b010_0000,
        st_rx_end   = 7'b100_0000
    } rx_state_e;

    // Byte idx of a 48-bit address, idx 0 = first byte on the wire
    function automatic logic [7:0] byte_of48(input logic [47:0] v, input logic [2:0] idx);
        case (idx)
            3'd0:    return v[47:40];
            3'd1:    return v[39:32];
            3'd2:    return v[31:24];
            3'd3:    return v[23:16];
            3'd4:    return v[15:8];
            3'd5:    return v[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // Byte idx of a 32-bit address, idx 0 = first byte on the wire
    function automatic logic [7:0] byte_of32(input logic [31:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    return v[31:24];
            2'd1:    return v[23:16];
            2'd2:    return v[15:8];
            default: return v[7:0];
        endcase
    endfunction

endpackage

// File: rtl/udp_rx_if.sv
// GMII receive input and UDP payload output bundle for udp_rx.
interface udp_rx_if;

    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rec_pkt_done;
    logic        rec_en;
    logic [31:0] rec_data;
    logic [15:0] rec_byte_num;

    // Source of GMII bytes, consumer of payload words
    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  rec_pkt_done, rec_en, rec_data, rec_byte_num
    );

    // The receiver itself
    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output rec_pkt_done, rec_en, rec_data, rec_byte_num
    );

endinterface

// File: rtl/udp_rx.sv
// GMII UDP receiver: strips preamble, Ethernet, IPv4 and UDP headers for
// frames addressed to this board and emits the payload as 32-bit words.
module udp_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
    input  logic     clk,
    input  logic     rst_n,
    udp_rx_if.slave  bus
);

    logic        dv_q;
    logic [7:0]  rxd_q;
    rx_state_e   state_q;
    logic [4:0]  cnt_q;
    logic [15:0] data_cnt_q;
    logic [15:0] udp_len_q;
    logic [15:0] pay_len_q;
    logic [23:0] word_q;
    logic        armed_q;
    logic        mac_bd_q;
    logic        mac_bc_q;
    logic        err_q;
    logic        rec_en_q;
    logic        done_q;
    logic [31:0] rec_data_q;
    logic [15:0] rec_num_q;

    logic        byte_bad;
    logic        err_d;
    logic        last_byte;
    logic [31:0] word_d;

    assign bus.rec_en       = rec_en_q;
    assign bus.rec_pkt_done = done_q;
    assign bus.rec_data     = rec_data_q;
    assign bus.rec_byte_num = rec_num_q;

    // Header field checks for the byte currently being parsed
    always_comb begin
        byte_bad = 1'b0;
        case (state_q)
            st_eth_head: begin
                if (cnt_q == 5'd12)      byte_bad = (rxd_q != ETH_TYPE_IP[15:8]);
                else if (cnt_q == 5'd13) byte_bad = (rxd_q != ETH_TYPE_IP[7:0]);
            end
            st_ip_head: begin
                if (cnt_q == 5'd0)       byte_bad = (rxd_q != IPV4_VER_IHL);
                else if (cnt_q == 5'd9)  byte_bad = (rxd_q != UDP_PROTO);
                else if (cnt_q >= 5'd16) byte_bad = (rxd_q != byte_of32(BOARD_IP, cnt_q[1:0]));
            end
            default: byte_bad = 1'b0;
        endcase
        err_d     = err_q | byte_bad;
        last_byte = ((data_cnt_q + 16'd1) == pay_len_q);
        // Left-align the bytes gathered so far; unused low bytes read as zero
        case (data_cnt_q[1:0])
            2'd0:    word_d = {rxd_q, 24'h0};
            2'd1:    word_d = {word_q[7:0], rxd_q, 16'h0};
            2'd2:    word_d = {word_q[15:0], rxd_q, 8'h0};
            default: word_d = {word_q[23:0], rxd_q};
        endcase
    end

    // GMII input register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q  <= 1'b0;
            rxd_q <= '0;
        end else begin
            dv_q  <= bus.gmii_rx_dv;
            rxd_q <= bus.gmii_rxd;
        end
    end

    // Frame parser FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= st_idle;
            cnt_q      <= '0;
            data_cnt_q <= '0;
            udp_len_q  <= '0;
            pay_len_q  <= '0;
            word_q     <= '0;
            armed_q    <= 1'b0;
            mac_bd_q   <= 1'b1;
            mac_bc_q   <= 1'b1;
            err_q      <= 1'b0;
            rec_en_q   <= 1'b0;
            done_q     <= 1'b0;
            rec_data_q <= '0;
            rec_num_q  <= '0;
        end else begin
            rec_en_q <= 1'b0;
            done_q   <= 1'b0;
            // A gap in dv is required before a new preamble is accepted
            if (!dv_q) armed_q <= 1'b1;
            case (state_q)
                st_idle: begin
                    if (dv_q && armed_q && rxd_q == PREAMBLE_BYTE) begin
                        state_q <= st_preamble;
                        cnt_q   <= '0;
                        armed_q <= 1'b0;
                    end
                end
                st_preamble: begin
                    if (!dv_q) begin
                        state_q <= st_idle;
                        cnt_q   <= '0;
                    end else if (cnt_q == 5'd6) begin
                        cnt_q    <= '0;
                        mac_bd_q <= 1'b1;
                        mac_bc_q <= 1'b1;
                        err_q    <= 1'b0;
                        state_q  <= (rxd_q == SFD_BYTE) ? st_eth_head : st_rx_end;
                    end else if (rxd_q == PREAMBLE_BYTE) begin
                        cnt_q <= cnt_q + 5'd1;
                    end else begin
                        state_q <= st_rx_end;
                        cnt_q   <= '0;
                    end
                end
                st_eth_head: begin
                    if (!dv_q) begin
                        state_q <= st_idle;
                        cnt_q   <= '0;
                    end else begin
                        if (cnt_q < 5'd6) begin
                            mac_bd_q <= mac_bd_q & (rxd_q == byte_of48(BOARD_MAC, cnt_q[2:0]));
                            mac_bc_q <= mac_bc_q & (rxd_q == 8'hFF);
                        end
                        err_q <= err_d;
                        if (cnt_q == 5'd13) begin
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                            state_q <= (!err_d && (mac_bd_q || mac_bc_q)) ? st_ip_head : st_rx_end;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                st_ip_head: begin
                    if (!dv_q) begin
                        state_q <= st_idle;
                        cnt_q   <= '0;
                    end else begin
                        err_q <= err_d;
                        if (cnt_q == 5'd19) begin
                            cnt_q   <= '0;
                            state_q <= err_d ? st_rx_end : st_udp_head;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                st_udp_head: begin
                    if (!dv_q) begin
                        state_q <= st_idle;
                        cnt_q   <= '0;
                    end else begin
                        if (cnt_q == 5'd4) udp_len_q[15:8] <= rxd_q;
                        if (cnt_q == 5'd5) udp_len_q[7:0]  <= rxd_q;
                        if (cnt_q == 5'd7) begin
                            cnt_q      <= '0;
                            data_cnt_q <= '0;
                            pay_len_q  <= udp_len_q - 16'd8;
                            state_q    <= (udp_len_q < 16'd9) ? st_rx_end : st_rx_data;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                st_rx_data: begin
                    if (!dv_q) begin
                        state_q    <= st_idle;
                        cnt_q      <= '0;
                        data_cnt_q <= '0;
                    end else begin
                        word_q     <= {word_q[15:0], rxd_q};
                        data_cnt_q <= data_cnt_q + 16'd1;
                        if (last_byte) begin
                            rec_en_q   <= 1'b1;
                            done_q     <= 1'b1;
                            rec_data_q <= word_d;
                            rec_num_q  <= pay_len_q;
                            data_cnt_q <= '0;
                            state_q    <= st_rx_end;
                        end else if (data_cnt_q[1:0] == 2'd3) begin
                            rec_en_q   <= 1'b1;
                            rec_data_q <= word_d;
                        end
                    end
                end
                st_rx_end: begin
                    if (!dv_q) begin
                        state_q <= st_idle;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= st_idle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// Directed frame bench for udp_rx with a frame-level payload model.
module tb_udp_rx;

    localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] IP    = {8'd192, 8'd168, 8'd1, 8'd123};
    localparam logic [31:0] IP_X  = {8'd192, 8'd168, 8'd1, 8'd100};

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [31:0] data;
        logic        done;
        logic [15:0] num;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q [$];

    udp_rx_if bus_if ();

    udp_rx #(.BOARD_MAC(MAC), .BOARD_IP(IP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic bq_t seq(input logic [7:0] start, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(start + 8'(i));
        return q;
    endfunction

    function automatic bq_t build(input logic [47:0] dmac, input logic [15:0] etype,
                                  input logic [7:0] proto, input logic [31:0] dip,
                                  input logic [15:0] ulen, input bq_t pay);
        bq_t f;
        logic [15:0] tot;
        logic [7:0] hdr [12];
        tot = ulen + 16'd20;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 6; i++) f.push_back(dmac[47 - 8*i -: 8]);
        for (int i = 0; i < 5; i++) f.push_back(8'h02 + 8'(i));
        f.push_back(8'h01);
        f.push_back(etype[15:8]); f.push_back(etype[7:0]);
        hdr = '{8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h01, 8'h00, 8'h00,
                8'h40, proto, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) f.push_back(hdr[i]);
        f.push_back(8'd192); f.push_back(8'd168); f.push_back(8'd1); f.push_back(8'd10);
        for (int i = 0; i < 4; i++) f.push_back(dip[31 - 8*i -: 8]);
        f.push_back(8'h04); f.push_back(8'hD2); f.push_back(8'h16); f.push_back(8'h2E);
        f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        foreach (pay[i]) f.push_back(pay[i]);
        while (f.size() < 68) f.push_back(8'h00);
        f.push_back(8'hDE); f.push_back(8'hAD); f.push_back(8'hBE); f.push_back(8'hEF);
        return f;
    endfunction

    // Frame-level model: decide acceptance from byte offsets, then cut payload into words
    task automatic predict(input bq_t f);
        int plen, avail, e;
        logic [31:0] w;
        if (f.size() < 50) return;
        for (int i = 0; i < 7; i++) if (f[i] != 8'h55) return;
        if (f[7] != 8'hD5) return;
        if ({f[8], f[9], f[10], f[11], f[12], f[13]} != MAC &&
            {f[8], f[9], f[10], f[11], f[12], f[13]} != BCAST) return;
        if ({f[20], f[21]} != 16'h0800) return;
        if (f[22] != 8'h45 || f[31] != 8'd17) return;
        if ({f[38], f[39], f[40], f[41]} != IP) return;
        plen  = int'({f[46], f[47]}) - 8;
        if (plen < 1) return;
        avail = f.size() - 50;
        for (int wi = 0; wi * 4 < plen; wi++) begin
            e = (wi * 4 + 4 < plen) ? wi * 4 + 4 : plen;
            if (e > avail) break;
            w = '0;
            for (int b = 0; b < 4; b++)
                if (wi * 4 + b < plen) w[31 - 8*b -: 8] = f[50 + wi * 4 + b];
            exp_q.push_back('{data: w, done: (e == plen), num: 16'(plen)});
        end
    endtask

    // Drive a frame byte by byte; rst_at >= 0 pulses reset for 3 cycles mid-frame
    task automatic send(input bq_t f, input int rst_at);
        foreach (f[i]) begin
            @(posedge clk); #1;
            if (i == rst_at) rst_n = 1'b0;
            if (i == rst_at + 3) rst_n = 1'b1;
            bus_if.gmii_rx_dv = 1'b1;
            bus_if.gmii_rxd   = f[i];
        end
        @(posedge clk); #1;
        bus_if.gmii_rx_dv = 1'b0;
        bus_if.gmii_rxd   = 8'h00;
        repeat (12) @(posedge clk);
        #1;
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Per-cycle compare against the model's expected event stream
    logic [31:0] held_d = '0;
    logic [15:0] held_n = '0;
    ev_t ev;
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (bus_if.rec_en !== 1'b0 || bus_if.rec_pkt_done !== 1'b0 ||
                bus_if.rec_data !== '0 || bus_if.rec_byte_num !== '0) begin
                errors++;
                $display("FAIL reset_outputs en=%b done=%b data=%h num=%0d exp all zero",
                         bus_if.rec_en, bus_if.rec_pkt_done, bus_if.rec_data, bus_if.rec_byte_num);
            end
            held_d = '0;
            held_n = '0;
        end else if (bus_if.rec_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rec_en data=%h done=%b exp no event",
                         bus_if.rec_data, bus_if.rec_pkt_done);
            end else begin
                ev = exp_q.pop_front();
                if (bus_if.rec_data !== ev.data || bus_if.rec_pkt_done !== ev.done ||
                    bus_if.rec_byte_num !== (ev.done ? ev.num : held_n)) begin
                    errors++;
                    $display("FAIL rec_word data=%h done=%b num=%0d exp data=%h done=%b num=%0d",
                             bus_if.rec_data, bus_if.rec_pkt_done, bus_if.rec_byte_num,
                             ev.data, ev.done, ev.done ? ev.num : held_n);
                end
                held_d = ev.data;
                if (ev.done) held_n = ev.num;
            end
        end else begin
            checks++;
            if (bus_if.rec_pkt_done !== 1'b0 || bus_if.rec_data !== held_d ||
                bus_if.rec_byte_num !== held_n) begin
                errors++;
                $display("FAIL idle_hold done=%b data=%h num=%0d exp done=0 data=%h num=%0d",
                         bus_if.rec_pkt_done, bus_if.rec_data, bus_if.rec_byte_num, held_d, held_n);
            end
        end
    end

    bq_t f;

    initial begin
        bus_if.gmii_rx_dv = 1'b0;
        bus_if.gmii_rxd   = 8'h00;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Unicast, 4-byte payload
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd12, seq(8'h01, 4));
        predict(f);
        chk("model_t1_count", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 1) begin
            chk("model_t1_data", exp_q[0].data, 32'h01020304);
            chk("model_t1_done", 32'(exp_q[0].done), 32'd1);
            chk("model_t1_num", 32'(exp_q[0].num), 32'd4);
        end
        send(f, -1);
        chk("t1_held_data", bus_if.rec_data, 32'h01020304);
        chk("t1_held_num", 32'(bus_if.rec_byte_num), 32'd4);

        // Broadcast, 6-byte payload with Ethernet padding
        f = build(BCAST, 16'h0800, 8'd17, IP, 16'd14, seq(8'hAA, 6));
        predict(f);
        chk("model_t2_count", 32'(exp_q.size()), 32'd2);
        if (exp_q.size() == 2) begin
            chk("model_t2_w0", exp_q[0].data, 32'hAAABACAD);
            chk("model_t2_w0_done", 32'(exp_q[0].done), 32'd0);
            chk("model_t2_w1", exp_q[1].data, 32'hAEAF0000);
            chk("model_t2_num", 32'(exp_q[1].num), 32'd6);
        end
        send(f, -1);
        chk("t2_held_data", bus_if.rec_data, 32'hAEAF0000);
        chk("t2_held_num", 32'(bus_if.rec_byte_num), 32'd6);

        // Foreign destination IP, then a valid 9-byte payload
        f = build(MAC, 16'h0800, 8'd17, IP_X, 16'd12, seq(8'h01, 4));
        predict(f);
        chk("model_t3_count", 32'(exp_q.size()), 32'd0);
        send(f, -1);
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd17, seq(8'h10, 9));
        predict(f);
        send(f, -1);
        chk("t3_held_data", bus_if.rec_data, 32'h18000000);

        // ARP EtherType and TCP protocol are ignored
        f = build(MAC, 16'h0806, 8'd17, IP, 16'd12, seq(8'h21, 4));
        predict(f);
        send(f, -1);
        f = build(MAC, 16'h0800, 8'd6, IP, 16'd12, seq(8'h31, 4));
        predict(f);
        send(f, -1);
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd12, seq(8'h41, 4));
        predict(f);
        send(f, -1);

        // Empty UDP payload, then single-byte payload
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd8, seq(8'h00, 0));
        predict(f);
        send(f, -1);
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd9, seq(8'h5A, 1));
        predict(f);
        send(f, -1);
        chk("t5_held_data", bus_if.rec_data, 32'h5A000000);
        chk("t5_held_num", 32'(bus_if.rec_byte_num), 32'd1);

        // Corrupt preamble byte
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd12, seq(8'h61, 4));
        f[3] = 8'h54;
        predict(f);
        send(f, -1);

        // dv drops after two of eight payload bytes, then a full 8-byte frame
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd16, seq(8'h71, 8));
        while (f.size() > 52) void'(f.pop_back());
        predict(f);
        chk("model_t7_count", 32'(exp_q.size()), 32'd0);
        send(f, -1);
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd16, seq(8'h81, 8));
        predict(f);
        send(f, -1);
        chk("t7_held_data", bus_if.rec_data, 32'h85868788);

        // Reset pulse inside the IP header, then a normal frame
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd12, seq(8'h91, 4));
        send(f, 30);
        chk("t8_post_reset_data", bus_if.rec_data, 32'h00000000);
        f = build(MAC, 16'h0800, 8'd17, IP, 16'd13, seq(8'hC1, 5));
        predict(f);
        send(f, -1);
        chk("t8_held_data", bus_if.rec_data, 32'hC5000000);
        chk("t8_held_num", 32'(bus_if.rec_byte_num), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_rx.md
UDP_RX -- requirements
Module: udp_rx

Interface
REQ-001 Parameter BOARD_MAC, 48'h00_11_22_33_44_55, local MAC address accepted as destination.
REQ-002 Parameter BOARD_IP, 192.168.1.123, local IPv4 address accepted as destination.
REQ-003 clk  input  1  GMII receive clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 gmii_rx_dv  input  1  GMII receive data valid.
REQ-006 gmii_rxd  input  8  GMII receive byte.
REQ-007 rec_pkt_done  output  1  one-cycle pulse, valid UDP payload fully delivered.
REQ-008 rec_en  output  1  one-cycle pulse, rec_data holds a new payload word.
REQ-009 rec_data  output  32  payload word, first byte in [31:24].
REQ-010 rec_byte_num  output  16  payload byte count (UDP length - 8), valid from rec_pkt_done onward.

Function
REQ-011 The block SHALL run a one-hot FSM: st_idle, st_preamble, st_eth_head, st_ip_head, st_udp_head, st_rx_data, st_rx_end.
REQ-012 The block SHALL register gmii_rx_dv/gmii_rxd once, then parse only bytes with registered dv=1.
REQ-013 st_idle SHALL advance to st_preamble on the first 0x55 byte; any other byte leaves it in st_idle.
REQ-014 st_preamble SHALL accept exactly six further 0x55 bytes then 0xD5 (7+1 bytes total) before entering st_eth_head; any mismatch SHALL go to st_rx_end.
REQ-015 st_eth_head SHALL take 14 bytes: destination MAC equal to BOARD_MAC or 48'hFF_FF_FF_FF_FF_FF, EtherType 0x0800; otherwise st_rx_end after byte 14.
REQ-016 st_ip_head SHALL require byte0 = 0x45, protocol (byte 9) = 17, destination IP (bytes 16-19) = BOARD_IP; any failure SHALL go to st_rx_end after byte 20; IP checksum is not checked.
REQ-017 st_udp_head SHALL take 8 bytes, capturing UDP length from bytes 4-5; ports and checksum are ignored.
REQ-018 UDP length < 9 SHALL go to st_rx_end with no rec_en and no rec_pkt_done.
REQ-019 st_rx_data SHALL pack bytes MSB-first into rec_data and pulse rec_en on the cycle after the 4th byte of each word is sampled.
REQ-020 For a final partial word, unused low bytes SHALL be zero and rec_en SHALL pulse on the cycle after the last payload byte.
REQ-021 rec_pkt_done SHALL pulse in the same cycle as the final rec_en, with rec_byte_num = UDP length - 8 in that cycle.
REQ-022 Bytes after the last payload byte (Ethernet pad, FCS) SHALL be discarded in st_rx_end; FCS is not checked.
REQ-023 st_rx_end SHALL return to st_idle on the first cycle registered dv = 0.
REQ-024 dv falling in any state other than st_idle or st_rx_end SHALL force st_idle, clear byte/word counters, and issue no rec_pkt_done; rec_en pulses already issued for that frame stand.
REQ-025 The payload byte counter SHALL be 16 bits; header byte counter 5 bits, cleared on every state change.
REQ-026 rec_data and rec_byte_num SHALL hold their last values between pulses.

Reset
REQ-027 During rst_n low, all outputs SHALL be 0 and the FSM SHALL be in st_idle.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, parsing SHALL resume only at a fresh preamble once dv has been low.

Structure
REQ-029 ETH_TYPE_IP (0x0800), UDP_PROTO (17), PREAMBLE_BYTE (0x55), SFD_BYTE (0xD5) and the FSM state encodings SHALL live in a shared eth_pkg package that udp_tx can also use.
REQ-030 The block SHALL be flat; no sub-module is needed. CRC checking is delegated to an optional instance of the existing CRC32 block outside udp_rx.

Verification
REQ-031 Frame to BOARD_MAC/BOARD_IP, UDP length 12, payload 01 02 03 04 -> one rec_en with rec_data 0x01020304, rec_pkt_done same cycle, rec_byte_num 4.
REQ-032 Broadcast MAC, payload of 6 bytes AA..AF (padded frame) -> rec_en with 0xAAABACAD, then rec_en with 0xAEAF0000, rec_pkt_done with rec_byte_num 6; pad bytes ignored.
REQ-033 Destination IP 192.168.1.100 -> no rec_en, no rec_pkt_done; next valid frame received normally.
REQ-034 EtherType 0x0806 or IP protocol 6 -> no outputs; FSM back in st_idle after dv low.
REQ-035 dv dropped after 2 payload bytes of an 8-byte payload -> no rec_en, no rec_pkt_done; following frame delivered correctly.
REQ-036 rst_n pulsed low during st_ip_head -> all outputs 0, and the next complete frame is delivered.
